// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM stage: set/branch resolution, 2-entry skid buffer, halt drain FSM
module ex_mem_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ofl,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_cout,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_cond,
  input  logic [W-1:0] in_st_data,
  input  logic [2:0]   in_wr_reg,
  input  logic         in_reg_we,
  input  logic         in_mem_rd,
  input  logic         in_mem_wr,
  input  logic         in_halt,
  input  logic [W-1:0] in_br_target,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [W-1:0] out_st_data,
  output logic [2:0]   out_wr_reg,
  output logic         out_reg_we,
  output logic         out_mem_rd,
  output logic         out_mem_wr,
  output logic         out_halt,
  output logic         out_err,
  output logic         redirect,
  output logic [W-1:0] redirect_pc,
  output logic         halted
);

  // payload layout: {result, st_data, wr_reg, reg_we, mem_rd, mem_wr, halt, err}
  localparam int PW = 2 * W + 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state;
  logic          in_ready_q;
  logic          halted_q;
  logic          redirect_q;
  logic [W-1:0]  redirect_pc_q;

  logic          m_valid, s_valid;
  logic [PW-1:0] m_pay, s_pay;
  logic          m_valid_n, s_valid_n;
  logic [PW-1:0] m_pay_n, s_pay_n;

  logic          s_flag;
  logic [W-1:0]  dec_result;
  logic          dec_err;
  logic          dec_taken;
  logic [PW-1:0] in_pay;

  logic          accept;
  logic          wr;
  logic          drain;
  logic          halt_enter;
  logic          halt_done;

  // Resolve set-condition results, branch outcome and reserved-code error from ALU flags
  always_comb begin
    s_flag     = alu_n ^ alu_ofl;
    dec_result = alu_out;
    dec_err    = 1'b0;
    dec_taken  = 1'b0;
    case (in_cond)
      4'd0:    dec_result = alu_out;
      4'd1:    dec_result = {{(W-1){1'b0}}, alu_z};
      4'd2:    dec_result = {{(W-1){1'b0}}, ~alu_z & ~s_flag};
      4'd3:    dec_result = {{(W-1){1'b0}}, ~s_flag};
      4'd4:    dec_result = {{(W-1){1'b0}}, alu_cout};
      4'd8:    dec_taken  = alu_z;
      4'd9:    dec_taken  = ~alu_z;
      4'd10:   dec_taken  = alu_n;
      4'd11:   dec_taken  = ~alu_n;
      4'd12:   dec_taken  = 1'b1;
      default: dec_err    = 1'b1;
    endcase
  end

  assign in_pay = {dec_result, in_st_data, in_wr_reg, in_reg_we, in_mem_rd,
                   in_mem_wr, in_halt, dec_err};

  // Handshakes: anything accepted while a redirect is showing is wrong-path and dropped
  assign accept     = in_valid & in_ready_q;
  assign wr         = accept & ~redirect_q;
  assign drain      = m_valid & out_ready;
  assign halt_enter = wr & in_halt;
  assign halt_done  = drain & m_pay[1];

  // Next-state of the M/S buffer; S is only written when M is full and not draining
  always_comb begin
    m_valid_n = m_valid;
    s_valid_n = s_valid;
    m_pay_n   = m_pay;
    s_pay_n   = s_pay;
    if (drain) begin
      if (s_valid) begin
        m_pay_n   = s_pay;
        s_valid_n = 1'b0;
      end else if (wr) begin
        m_pay_n = in_pay;
      end else begin
        m_valid_n = 1'b0;
      end
    end else if (wr) begin
      if (!m_valid) begin
        m_valid_n = 1'b1;
        m_pay_n   = in_pay;
      end else begin
        s_valid_n = 1'b1;
        s_pay_n   = in_pay;
      end
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_pay   <= '0;
      s_pay   <= '0;
    end else begin
      m_valid <= m_valid_n;
      s_valid <= s_valid_n;
      m_pay   <= m_pay_n;
      s_pay   <= s_pay_n;
    end
  end

  // Taken-branch redirect pulse; a dropped instruction can never redirect, so no back-to-back pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= wr & dec_taken;
      if (wr & dec_taken) begin
        redirect_pc_q <= in_br_target;
      end
    end
  end

  // Halt FSM with registered in_ready/halted derived from the upcoming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      in_ready_q <= 1'b1;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_enter) begin
            state <= DRAIN;
          end
          in_ready_q <= ~s_valid_n & ~halt_enter;
          halted_q   <= 1'b0;
        end
        DRAIN: begin
          if (halt_done) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
          in_ready_q <= 1'b0;
        end
        HALTED: begin
          in_ready_q <= 1'b0;
          halted_q   <= 1'b1;
        end
        default: begin
          state      <= RUN;
          in_ready_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign halted      = halted_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign out_valid   = m_valid;
  assign {out_result, out_st_data, out_wr_reg, out_reg_we, out_mem_rd,
          out_mem_wr, out_halt, out_err} = m_pay;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_out;
  logic        alu_ofl, alu_z, alu_n, alu_cout;
  logic        in_valid, in_ready;
  logic [3:0]  in_cond;
  logic [15:0] in_st_data;
  logic [2:0]  in_wr_reg;
  logic        in_reg_we, in_mem_rd, in_mem_wr, in_halt;
  logic [15:0] in_br_target;
  logic        out_valid, out_ready;
  logic [15:0] out_result, out_st_data;
  logic [2:0]  out_wr_reg;
  logic        out_reg_we, out_mem_rd, out_mem_wr, out_halt, out_err;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  ex_mem_stage #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_z(alu_z), .alu_n(alu_n), .alu_cout(alu_cout),
    .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond), .in_st_data(in_st_data),
    .in_wr_reg(in_wr_reg), .in_reg_we(in_reg_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_halt(in_halt), .in_br_target(in_br_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_st_data(out_st_data), .out_wr_reg(out_wr_reg), .out_reg_we(out_reg_we),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_halt(out_halt), .out_err(out_err),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [40:0] dut_pay;
  assign dut_pay = {out_result, out_st_data, out_wr_reg, out_reg_we, out_mem_rd,
                    out_mem_wr, out_halt, out_err};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; alu_out = 0; alu_ofl = 0; alu_z = 0; alu_n = 0; alu_cout = 0;
    in_cond = 0; in_st_data = 0; in_wr_reg = 0; in_reg_we = 0; in_mem_rd = 0;
    in_mem_wr = 0; in_halt = 0; in_br_target = 0;
  endtask

  task automatic push(input logic [3:0] c, input logic [15:0] a, input logic hlt,
                      input logic [15:0] tgt);
    idle();
    in_valid = 1; in_cond = c; alu_out = a; in_halt = hlt; in_br_target = tgt;
  endtask

  // Reference: what the stage must deliver for one instruction, from the condition-code table
  function automatic logic [40:0] ref_pay(input logic [3:0] c, input logic [15:0] a,
      input logic o, input logic z, input logic n, input logic co, input logic [15:0] st,
      input logic [2:0] wreg, input logic we, input logic rd, input logic wm, input logic h);
    logic [15:0] r;
    logic e;
    logic s;
    s = n ^ o;
    e = (c >= 5 && c <= 7) || c >= 13;
    if (c == 1) r = z ? 16'd1 : 16'd0;
    else if (c == 2) r = (!z && !s) ? 16'd1 : 16'd0;
    else if (c == 3) r = !s ? 16'd1 : 16'd0;
    else if (c == 4) r = co ? 16'd1 : 16'd0;
    else r = a;
    return {r, st, wreg, we, rd, wm, h, e};
  endfunction

  function automatic logic ref_taken(input logic [3:0] c, input logic z, input logic n);
    if (c == 8) return z;
    if (c == 9) return !z;
    if (c == 10) return n;
    if (c == 11) return !n;
    return c == 12;
  endfunction

  typedef struct {
    logic [3:0]  cond;
    logic [15:0] aout;
    logic        ofl, z, n, cout;
    logic [15:0] exp_res;
    logic        exp_err;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[16];

  logic [40:0] q[$];
  logic        m_redir;
  logic [15:0] m_pc;
  logic        acc, wr, drn, tk;

  initial begin
    vecs[0]  = '{4'd2,  16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[1]  = '{4'd2,  16'h1111, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{4'd3,  16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[3]  = '{4'd4,  16'h3333, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4]  = '{4'd1,  16'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[5]  = '{4'd1,  16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{4'd0,  16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    vecs[7]  = '{4'd2,  16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{4'd3,  16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{4'd8,  16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1};
    vecs[10] = '{4'd9,  16'h2345, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[11] = '{4'd10, 16'h3456, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3456, 1'b0, 1'b1};
    vecs[12] = '{4'd11, 16'h4567, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4567, 1'b0, 1'b0};
    vecs[13] = '{4'd12, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5678, 1'b0, 1'b1};
    vecs[14] = '{4'd13, 16'h6789, 1'b0, 1'b0, 1'b0, 1'b0, 16'h6789, 1'b1, 1'b0};
    vecs[15] = '{4'd5,  16'h789A, 1'b0, 1'b0, 1'b0, 1'b0, 16'h789A, 1'b1, 1'b0};

    idle();
    out_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_redirect", redirect, 0);
    chk("reset_halted", halted, 0);
    chk("reset_out_result", out_result, 0);
    rst_n = 1;
    @(negedge clk);

    // decode table, one instruction at a time with MEM always ready
    for (int i = 0; i < 16; i++) begin
      chk("vec_in_ready", in_ready, 1);
      idle();
      in_valid = 1; in_cond = vecs[i].cond; alu_out = vecs[i].aout;
      alu_ofl = vecs[i].ofl; alu_z = vecs[i].z; alu_n = vecs[i].n; alu_cout = vecs[i].cout;
      in_br_target = 16'h0100 + 16'(i);
      out_ready = 1;
      @(negedge clk);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_out_result", out_result, vecs[i].exp_res);
      chk("vec_out_err", out_err, vecs[i].exp_err);
      chk("vec_redirect", redirect, vecs[i].exp_taken);
      if (vecs[i].exp_taken) chk("vec_redirect_pc", redirect_pc, 16'h0100 + 16'(i));
      idle();
      @(negedge clk);
      chk("vec_drained", out_valid, 0);
    end

    // backpressure: three offered, two taken, order kept after release
    out_ready = 0;
    push(4'd0, 16'h0011, 0, 0);
    @(negedge clk);
    chk("bp_in_ready_1", in_ready, 1);
    chk("bp_result_1", out_result, 16'h0011);
    push(4'd0, 16'h0022, 0, 0);
    @(negedge clk);
    chk("bp_in_ready_2", in_ready, 0);
    chk("bp_result_2", out_result, 16'h0011);
    push(4'd0, 16'h0033, 0, 0);
    @(negedge clk);
    chk("bp_in_ready_3", in_ready, 0);
    chk("bp_held", out_result, 16'h0011);
    out_ready = 1;
    @(negedge clk);
    chk("bp_second", out_result, 16'h0022);
    chk("bp_in_ready_4", in_ready, 1);
    @(negedge clk);
    chk("bp_third", out_result, 16'h0033);
    chk("bp_third_valid", out_valid, 1);
    idle();
    @(negedge clk);
    chk("bp_empty", out_valid, 0);

    // taken BNEZ, then a wrong-path instruction during the redirect cycle
    push(4'd9, 16'h5555, 0, 16'h0040);
    alu_z = 0;
    @(negedge clk);
    chk("br_redirect", redirect, 1);
    chk("br_redirect_pc", redirect_pc, 16'h0040);
    chk("br_payload", out_result, 16'h5555);
    push(4'd0, 16'h7777, 0, 0);
    @(negedge clk);
    chk("br_redirect_one_cycle", redirect, 0);
    chk("br_dropped", out_valid, 0);
    idle();
    @(negedge clk);

    // halt drain
    out_ready = 0;
    push(4'd0, 16'h00AA, 1, 0);
    @(negedge clk);
    chk("halt_in_ready", in_ready, 0);
    chk("halt_not_yet", halted, 0);
    chk("halt_payload", out_halt, 1);
    push(4'd0, 16'h00BB, 0, 0);
    @(negedge clk);
    chk("halt_drain_hold", out_result, 16'h00AA);
    chk("halt_drain_in_ready", in_ready, 0);
    out_ready = 1;
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_out_empty", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_persist", halted, 1);
      chk("halt_no_output", out_valid, 0);
    end
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("halt_cleared", halted, 0);
    chk("halt_ready_again", in_ready, 1);

    // reset with both entries full and a redirect pending
    out_ready = 0;
    push(4'd0, 16'h0101, 0, 0);
    @(negedge clk);
    push(4'd12, 16'h0202, 0, 16'h0ABC);
    @(negedge clk);
    chk("rst_pre_redirect", redirect, 1);
    chk("rst_pre_in_ready", in_ready, 0);
    idle();
    rst_n = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    out_ready = 1;
    push(4'd13, 16'h4321, 0, 0);
    @(negedge clk);
    chk("rsv_err", out_err, 1);
    chk("rsv_result", out_result, 16'h4321);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;

    // randomized traffic against the queue model
    q.delete();
    m_redir = 0;
    m_pc = 0;
    for (int c = 0; c < 1500; c++) begin
      chk("rnd_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) chk("rnd_payload", dut_pay, q[0]);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      chk("rnd_redirect", redirect, m_redir);
      if (m_redir) chk("rnd_redirect_pc", redirect_pc, m_pc);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_cond = 4'($urandom_range(0, 15));
      alu_out = 16'($urandom);
      alu_ofl = 1'($urandom); alu_z = 1'($urandom); alu_n = 1'($urandom); alu_cout = 1'($urandom);
      in_st_data = 16'($urandom);
      in_wr_reg = 3'($urandom);
      in_reg_we = 1'($urandom); in_mem_rd = 1'($urandom); in_mem_wr = 1'($urandom);
      in_halt = 0;
      in_br_target = 16'($urandom);
      acc = in_valid && (q.size() < 2);
      wr = acc && !m_redir;
      drn = (q.size() > 0) && out_ready;
      tk = ref_taken(in_cond, alu_z, alu_n);
      if (drn) void'(q.pop_front());
      if (wr) q.push_back(ref_pay(in_cond, alu_out, alu_ofl, alu_z, alu_n, alu_cout,
                                  in_st_data, in_wr_reg, in_reg_we, in_mem_rd,
                                  in_mem_wr, in_halt));
      m_redir = wr && tk;
      if (wr && tk) m_pc = in_br_target;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
